// File: rtl/xadc_drp_scanner.sv
// xadc_drp_scanner: DRP read master that scans XADC VAUX result registers
// round-robin, keeps the latest 12-bit code per channel and strobes each new
// sample towards the display path. A registered read port exposes the bank.
`timescale 1ns/1ps
module xadc_drp_scanner #(
  parameter int         NUM_CH    = 13,
  parameter logic [7:0] ADDR_BASE = 8'h10,
  parameter int         PERIOD    = 100000,
  parameter int         TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  input  logic        drp_busy,
  input  logic        drp_drdy,
  input  logic [15:0] drp_do,
  output logic        sample_valid,
  output logic [3:0]  sample_ch,
  output logic [11:0] sample_data,
  output logic        sample_ovr,
  output logic        scan_done,
  output logic        timeout_err,
  input  logic        err_clr,
  input  logic [3:0]  rd_ch,
  output logic [11:0] rd_data
);

  localparam int TICK_W = $clog2(PERIOD);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    WAIT_TICK,
    REQ,
    WAIT_RDY,
    STORE,
    NEXT
  } state_t;

  state_t            state, state_nx;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_wrap;
  logic              pending;
  logic [3:0]        ch;
  logic [TO_W-1:0]   to_cnt;
  logic [11:0]       bank [NUM_CH];

  // Decisions taken by the FSM in the current cycle
  logic start, issue, accept, abandon, store, advance, last;

  // Codes above the full-scale guard band are flagged as over-range
  function automatic logic is_over_range(input logic [15:0] code);
    return code > 16'hFFD0;
  endfunction

  assign drp_dwe   = 1'b0;
  assign tick_wrap = (tick_cnt == TICK_W'(PERIOD - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_TICK;
    else     state <= state_nx;
  end

  // Next-state logic and per-cycle decisions of the scan sequencer
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    issue    = 1'b0;
    accept   = 1'b0;
    abandon  = 1'b0;
    store    = 1'b0;
    advance  = 1'b0;
    last     = 1'b0;
    case (state)
      WAIT_TICK: if (pending) begin
        start    = 1'b1;
        state_nx = REQ;
      end
      REQ: if (!drp_busy) begin
        issue    = 1'b1;
        state_nx = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (drp_drdy) begin
          accept   = 1'b1;
          state_nx = STORE;
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          abandon  = 1'b1;
          state_nx = NEXT;
        end
      end
      STORE: begin
        store    = 1'b1;
        state_nx = NEXT;
      end
      NEXT: begin
        if (ch == 4'(NUM_CH - 1)) begin
          last     = 1'b1;
          state_nx = WAIT_TICK;
        end else begin
          advance  = 1'b1;
          state_nx = REQ;
        end
      end
      default: state_nx = WAIT_TICK;
    endcase
  end

  // Free-running scan-period counter; a wrap leaves one pending scan request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      pending  <= 1'b0;
    end else begin
      tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
      if (tick_wrap)  pending <= 1'b1;
      else if (start) pending <= 1'b0;
    end
  end

  // Channel index and drdy wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch     <= '0;
      to_cnt <= '0;
    end else begin
      if (start)        ch <= '0;
      else if (advance) ch <= ch + 4'd1;
      if (issue)                  to_cnt <= '0;
      else if (state == WAIT_RDY) to_cnt <= to_cnt + 1'b1;
    end
  end

  // DRP request: single-cycle enable with the channel address held alongside
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drp_den   <= 1'b0;
      drp_daddr <= '0;
    end else begin
      drp_den <= issue;
      if (issue) drp_daddr <= 7'(ADDR_BASE + {4'd0, ch});
    end
  end

  // Sample strobe, scan-complete strobe and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      sample_ovr   <= 1'b0;
      scan_done    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      sample_valid <= accept;
      if (accept) begin
        sample_ch   <= ch;
        sample_data <= drp_do[15:4];
        sample_ovr  <= is_over_range(drp_do);
      end
      scan_done <= last;
      if (abandon)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

  // Result bank, written at the end of the STORE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
    end else if (store) begin
      bank[ch] <= sample_data;
    end
  end

  // Registered read port; unused channel selects read as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         rd_data <= '0;
    else if (rd_ch < 4'(NUM_CH))     rd_data <= bank[rd_ch];
    else                             rd_data <= '0;
  end

endmodule

// File: tb/tb_xadc_drp_scanner.sv
// tb_xadc_drp_scanner: drives the scanner with a behavioural XADC responder and
// checks address order, samples, read port, timeout, busy and reset handling.
`timescale 1ns/1ps
module tb_xadc_drp_scanner;

  localparam int NUM_CH  = 13;
  localparam int PERIOD  = 64;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  drp_daddr;
  logic        drp_den, drp_dwe, drp_busy, drp_drdy;
  logic [15:0] drp_do;
  logic        sample_valid, sample_ovr, scan_done, timeout_err, err_clr;
  logic [3:0]  sample_ch, rd_ch;
  logic [11:0] sample_data, rd_data;

  always #5 clk = ~clk;

  xadc_drp_scanner #(.NUM_CH(NUM_CH), .ADDR_BASE(8'h10), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe),
    .drp_busy(drp_busy), .drp_drdy(drp_drdy), .drp_do(drp_do),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .sample_ovr(sample_ovr), .scan_done(scan_done), .timeout_err(timeout_err),
    .err_clr(err_clr), .rd_ch(rd_ch), .rd_data(rd_data)
  );

  typedef struct packed {
    logic        ovr;
    logic [3:0]  ch;
    logic [11:0] data;
  } samp_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // XADC responder configuration
  logic [15:0] chv  [NUM_CH];
  bit          mute [NUM_CH];
  int          lat;

  // Event logs filled by the monitor
  int    den_addr_q[$];
  int    den_cyc_q[$];
  samp_t samp_q[$];
  int    done_cyc_q[$];
  int    done_cnt     = 0;
  int    busy_viol    = 0;
  int    err_rise_cyc = -1;

  // Reference: stored code per channel and expected samples of one scan
  logic [11:0] ref_bank [NUM_CH];
  samp_t       exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural XADC: answers each den with the channel's table value after lat cycles
  initial begin
    int          cnt;
    int          c;
    logic [15:0] resp;
    cnt = 0; resp = 0; drp_drdy = 1'b0; drp_do = 16'h0;
    forever begin
      @(negedge clk);
      drp_drdy = 1'b0;
      drp_do   = 16'($urandom);
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          drp_drdy = 1'b1;
          drp_do   = resp;
        end
      end
      if (drp_den === 1'b1 && !rst) begin
        c = int'(drp_daddr) - 'h10;
        if (c >= 0 && c < NUM_CH && !mute[c]) begin
          cnt  = lat;
          resp = chv[c];
        end
      end
    end
  end

  // Monitor: logs DUT events once per cycle
  initial begin
    samp_t s;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (drp_den === 1'b1) begin
          den_addr_q.push_back(int'(drp_daddr));
          den_cyc_q.push_back(cyc);
          if (drp_busy) busy_viol++;
        end
        if (sample_valid === 1'b1) begin
          s.ovr = sample_ovr; s.ch = sample_ch; s.data = sample_data;
          samp_q.push_back(s);
        end
        if (scan_done === 1'b1) begin
          done_cnt++;
          done_cyc_q.push_back(cyc);
        end
        if (timeout_err === 1'b1 && err_rise_cyc < 0) err_rise_cyc = cyc;
      end
    end
  end

  task automatic clear_logs();
    den_addr_q.delete(); den_cyc_q.delete(); samp_q.delete(); done_cyc_q.delete();
    busy_viol = 0; err_rise_cyc = -1;
  endtask

  task automatic build_exp();
    exp_q.delete();
    for (int i = 0; i < NUM_CH; i++) begin
      samp_t s;
      if (!mute[i]) begin
        s.ovr = (chv[i] > 16'hFFD0); s.ch = 4'(i); s.data = chv[i][15:4];
        exp_q.push_back(s);
      end
    end
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    int start;
    start = done_cnt;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt != start) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [40:0] obs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    obs = {drp_daddr, drp_den, drp_dwe, sample_valid, sample_ch, sample_data,
           sample_ovr, scan_done, timeout_err, rd_data};
    tests++;
    if (obs !== 41'h0) begin
      fails++; $display("FAIL reset_outputs: got %h want 0", obs);
    end
  endtask

  task automatic test_scan();
    bit to;
    int rel;
    for (int i = 0; i < NUM_CH; i++) begin
      chv[i] = 16'($urandom); mute[i] = 1'b0;
    end
    lat = 3;
    clear_logs();
    rst = 1'b0;
    rel = cyc;
    wait_done(600, to);
    tests++;
    if (to) begin fails++; $display("FAIL scan1_timeout: no scan_done within 600 cycles"); end
    tests++;
    if (den_cyc_q.size() == 0 || den_cyc_q[0] - rel < PERIOD || den_cyc_q[0] - rel > PERIOD + 4) begin
      fails++; $display("FAIL first_den_after_tick: den at +%0d cycles, want %0d..%0d",
                        den_cyc_q.size() ? den_cyc_q[0] - rel : -1, PERIOD, PERIOD + 4);
    end
    tests++;
    if (den_addr_q.size() != NUM_CH) begin
      fails++; $display("FAIL scan1_den_count: got %0d want %0d", den_addr_q.size(), NUM_CH);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      tests++;
      if (den_addr_q[i] != 'h10 + i) begin
        fails++; $display("FAIL scan1_addr[%0d]: got %h want %h", i, den_addr_q[i], 'h10 + i);
      end
    end
    build_exp();
    tests++;
    if (samp_q.size() != exp_q.size()) begin
      fails++; $display("FAIL scan1_sample_count: got %0d want %0d", samp_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (samp_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL scan1_sample[%0d]: got %h want %h", i, samp_q[i], exp_q[i]);
      end
    end
    tests++;
    if (done_cnt != 1) begin
      fails++; $display("FAIL scan1_done_count: got %0d want 1", done_cnt);
    end
    for (int i = 0; i < NUM_CH; i++) ref_bank[i] = chv[i][15:4];
  endtask

  task automatic test_read_port();
    logic [11:0] want;
    int          c;
    for (int k = 0; k < 12; k++) begin
      c = (k < 2) ? 13 + 2 * k : int'($urandom_range(0, 15));
      rd_ch = 4'(c);
      @(posedge clk); #1;
      want = (c < NUM_CH) ? ref_bank[c] : 12'h0;
      tests++;
      if (rd_data !== want) begin
        fails++; $display("FAIL read_port[ch %0d]: got %h want %h", c, rd_data, want);
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_values();
    bit to;
    wait_done(600, to);
    chv[0] = 16'hFFE0; chv[3] = 16'hFFD0; chv[4] = 16'hFFD1; chv[5] = 16'h8000;
    clear_logs();
    wait_done(600, to);
    tests++;
    if (to) begin fails++; $display("FAIL values_timeout: no scan_done within 600 cycles"); end
    build_exp();
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (samp_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL values_sample[%0d]: got %h want %h", i, samp_q[i], exp_q[i]);
      end
    end
    tests++;
    if (samp_q[5].data !== 12'h800 || samp_q[5].ovr !== 1'b0) begin
      fails++; $display("FAIL ch5_mid_scale: got data %h ovr %b want 800 0", samp_q[5].data, samp_q[5].ovr);
    end
    tests++;
    if (samp_q[0].data !== 12'hFFE || samp_q[0].ovr !== 1'b1) begin
      fails++; $display("FAIL ch0_over_range: got data %h ovr %b want ffe 1", samp_q[0].data, samp_q[0].ovr);
    end
    for (int i = 0; i < NUM_CH; i++) ref_bank[i] = chv[i][15:4];
    @(negedge clk); #1;
    rd_ch = 4'd5;
    @(posedge clk); #1;
    tests++;
    if (rd_data !== 12'h800) begin
      fails++; $display("FAIL rd_ch5: got %h want 800", rd_data);
    end
  endtask

  task automatic test_timeout();
    bit to;
    wait_done(600, to);
    mute[7] = 1'b1;
    clear_logs();
    tests++;
    if (timeout_err !== 1'b0) begin
      fails++; $display("FAIL timeout_err_idle: got %b want 0", timeout_err);
    end
    wait_done(1500, to);
    tests++;
    if (to) begin fails++; $display("FAIL timeout_scan: no scan_done within 1500 cycles"); end
    tests++;
    if (timeout_err !== 1'b1) begin
      fails++; $display("FAIL timeout_err_set: got %b want 1", timeout_err);
    end
    tests++;
    if (den_cyc_q.size() < 8 || err_rise_cyc - den_cyc_q[7] < TIMEOUT || err_rise_cyc - den_cyc_q[7] > TIMEOUT + 1) begin
      fails++; $display("FAIL timeout_delay: got %0d cycles want %0d..%0d",
                        den_cyc_q.size() >= 8 ? err_rise_cyc - den_cyc_q[7] : -1, TIMEOUT, TIMEOUT + 1);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      tests++;
      if (den_addr_q[i] != 'h10 + i) begin
        fails++; $display("FAIL timeout_addr[%0d]: got %h want %h", i, den_addr_q[i], 'h10 + i);
      end
    end
    build_exp();
    tests++;
    if (samp_q.size() != NUM_CH - 1) begin
      fails++; $display("FAIL timeout_sample_count: got %0d want %0d", samp_q.size(), NUM_CH - 1);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (samp_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL timeout_sample[%0d]: got %h want %h", i, samp_q[i], exp_q[i]);
      end
    end
    mute[7] = 1'b0;
    rd_ch = 4'd7;
    @(posedge clk); #1;
    tests++;
    if (rd_data !== ref_bank[7]) begin
      fails++; $display("FAIL bank7_kept: got %h want %h", rd_data, ref_bank[7]);
    end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    tests++;
    if (timeout_err !== 1'b0) begin
      fails++; $display("FAIL err_clr: got %b want 0", timeout_err);
    end
  endtask

  task automatic test_busy();
    bit to;
    int fall;
    wait_done(1500, to);
    clear_logs();
    drp_busy = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    tests++;
    if (den_addr_q.size() != 0) begin
      fails++; $display("FAIL den_while_busy: got %0d den pulses want 0", den_addr_q.size());
    end
    drp_busy = 1'b0;
    fall = cyc;
    wait_done(600, to);
    tests++;
    if (to) begin fails++; $display("FAIL busy_scan: no scan_done within 600 cycles"); end
    tests++;
    if (den_cyc_q.size() == 0 || den_cyc_q[0] < fall + 1) begin
      fails++; $display("FAIL den_after_busy: got cycle %0d want >= %0d",
                        den_cyc_q.size() ? den_cyc_q[0] : -1, fall + 1);
    end
    tests++;
    if (busy_viol != 0 || den_addr_q.size() != NUM_CH || samp_q.size() != NUM_CH) begin
      fails++; $display("FAIL busy_scan_shape: got viol %0d den %0d samples %0d want 0 %0d %0d",
                        busy_viol, den_addr_q.size(), samp_q.size(), NUM_CH, NUM_CH);
    end
  endtask

  task automatic test_back_to_back();
    bit to, to2;
    wait_done(600, to);
    lat = 10;
    for (int i = 0; i < NUM_CH; i++) chv[i] = 16'($urandom);
    clear_logs();
    wait_done(800, to);
    wait_done(800, to2);
    tests++;
    if (to || to2) begin fails++; $display("FAIL b2b_timeout: scans did not complete"); end
    tests++;
    if (den_addr_q.size() != 2 * NUM_CH || samp_q.size() != 2 * NUM_CH) begin
      fails++; $display("FAIL b2b_counts: got den %0d samples %0d want %0d", den_addr_q.size(), samp_q.size(), 2 * NUM_CH);
    end
    build_exp();
    for (int i = 0; i < 2 * NUM_CH; i++) begin
      tests++;
      if (den_addr_q[i] != 'h10 + (i % NUM_CH) || samp_q[i] !== exp_q[i % NUM_CH]) begin
        fails++; $display("FAIL b2b_item[%0d]: got addr %h sample %h want %h %h",
                          i, den_addr_q[i], samp_q[i], 'h10 + (i % NUM_CH), exp_q[i % NUM_CH]);
      end
    end
    tests++;
    if (done_cyc_q.size() < 1 || den_cyc_q.size() <= NUM_CH || den_cyc_q[NUM_CH] - done_cyc_q[0] > 3) begin
      fails++; $display("FAIL b2b_restart: next scan den not within 3 cycles of scan_done");
    end
    for (int i = 0; i < NUM_CH; i++) ref_bank[i] = chv[i][15:4];
  endtask

  task automatic test_reset_mid_read();
    bit          to;
    logic [40:0] obs;
    wait_done(800, to);
    clear_logs();
    for (int i = 0; i < 20 && den_addr_q.size() == 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    obs = {drp_daddr, drp_den, drp_dwe, sample_valid, sample_ch, sample_data,
           sample_ovr, scan_done, timeout_err, rd_data};
    tests++;
    if (obs !== 41'h0) begin
      fails++; $display("FAIL async_reset_outputs: got %h want 0", obs);
    end
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
    for (int i = 0; i < NUM_CH; i++) ref_bank[i] = 12'h0;
    for (int i = 0; i < NUM_CH; i++) begin
      rd_ch = 4'(i);
      @(posedge clk); #1;
      tests++;
      if (rd_data !== ref_bank[i]) begin
        fails++; $display("FAIL bank_cleared[%0d]: got %h want %h", i, rd_data, ref_bank[i]);
      end
      @(negedge clk); #1;
    end
    tests++;
    if (samp_q.size() != 0 || den_addr_q.size() != 0) begin
      fails++; $display("FAIL late_drdy_ignored: got samples %0d den %0d want 0 0", samp_q.size(), den_addr_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; drp_busy = 1'b0; err_clr = 1'b0; rd_ch = 4'd0; lat = 3;
    for (int i = 0; i < NUM_CH; i++) begin
      chv[i] = 16'h0; mute[i] = 1'b0; ref_bank[i] = 12'h0;
    end
    test_reset();
    test_scan();
    test_read_port();
    test_values();
    test_timeout();
    test_busy();
    test_back_to_back();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
